// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch: a debounced-by-synchronizer start/stop button toggles
// run/stop, and a prescaler advances the BCD count once every TICK_DIV clocks.
module bcd_stopwatch #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clr,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       running,
  output logic       overflow
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic sync1_q, sync2_q, prev_q;
  logic [1:0] warm_q;
  logic startEdge;
  logic tick;

  logic [PW-1:0] pre_q, pre_d;
  logic [3:0][3:0] digs_q, digs_d;
  logic ovf_q, ovf_d;
  logic carry;

  // During the first two edges after reset prev tracks sync1, so a button already
  // held high at reset release lands in prev and sync2 together and is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      warm_q  <= 2'd0;
    end else begin
      sync1_q <= start_stop;
      sync2_q <= sync1_q;
      prev_q  <= (warm_q != 2'd2) ? sync1_q : sync2_q;
      warm_q  <= (warm_q == 2'd2) ? 2'd2 : warm_q + 2'd1;
    end
  end

  assign startEdge = sync2_q & ~prev_q;
  assign tick      = (state_q == RUNNING) && (pre_q == PRE_LAST);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    digs_d  = digs_q;
    ovf_d   = ovf_q;
    carry   = 1'b0;
    if (clr) begin
      state_d = STOPPED;
      pre_d   = '0;
      digs_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      if (tick) begin
        pre_d = '0;
        carry = 1'b1;
        // Ripple the increment through the digits; a carry out of the top digit is the wrap.
        for (int i = 0; i < 4; i++) begin
          if (carry) begin
            if (digs_q[i] >= 4'd9) begin
              digs_d[i] = 4'd0;
            end else begin
              digs_d[i] = digs_q[i] + 4'd1;
              carry     = 1'b0;
            end
          end
        end
        if (carry) begin
          ovf_d = 1'b1;
        end
      end else if (state_q == RUNNING) begin
        pre_d = pre_q + PW'(1);
      end
      if (startEdge) begin
        state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STOPPED;
      pre_q   <= '0;
      digs_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      digs_q  <= digs_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dig0     = digs_q[0];
  assign dig1     = digs_q[1];
  assign dig2     = digs_q[2];
  assign dig3     = digs_q[3];
  assign running  = (state_q == RUNNING);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: an integer-count model is compared on every cycle, and
// directed sequences pin counting, wrap, pause/resume, clear priority and async reset.
module tb_bcd_stopwatch;

  localparam int unsigned TICK_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic startStop = 1'b0;
  logic clr = 1'b0;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic running, overflow;

  int checks = 0;
  int failures = 0;

  int mCnt = 0;
  int mPre = 0;
  bit mRun = 1'b0;
  bit mOvf = 1'b0;
  int mEdges = 0;
  bit h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

  bcd_stopwatch #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .start_stop(startStop),
    .clr(clr),
    .dig0(dig0),
    .dig1(dig1),
    .dig2(dig2),
    .dig3(dig3),
    .running(running),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] toBcd(input int c);
    return {4'(c / 1000 % 10), 4'(c / 100 % 10), 4'(c / 10 % 10), 4'(c % 10)};
  endfunction

  function automatic logic [15:0] dutDigits();
    return {dig3, dig2, dig1, dig0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic stepEdges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDigits(input logic [15:0] target, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (dutDigits() == target) break;
    end
    checkOutput("waitDigits", {16'h0, dutDigits()}, {16'h0, target});
  endtask

  // Reference: the count is a plain integer; a button edge is a 0->1 change in the
  // sampled input two samples back, ignored for the first three edges after reset.
  always @(posedge clk or posedge rst) begin : modelStep
    int k, nCnt, nPre;
    bit se, tk, nRun, nOvf;
    if (rst) begin
      mCnt <= 0; mPre <= 0; mRun <= 1'b0; mOvf <= 1'b0;
      mEdges <= 0; h1 <= 1'b0; h2 <= 1'b0; h3 <= 1'b0;
    end else begin
      k  = mEdges + 1;
      se = (k >= 4) && h2 && !h3;
      tk = mRun && (mPre == int'(TICK_DIV) - 1);
      nCnt = mCnt; nPre = mPre; nRun = mRun; nOvf = mOvf;
      if (clr) begin
        nCnt = 0; nPre = 0; nRun = 1'b0; nOvf = 1'b0;
      end else begin
        if (tk) begin
          nOvf = mOvf || (mCnt == 9999);
          nCnt = (mCnt + 1) % 10000;
          nPre = 0;
        end else if (mRun) begin
          nPre = mPre + 1;
        end
        if (se) nRun = !mRun;
      end
      mCnt <= nCnt; mPre <= nPre; mRun <= nRun; mOvf <= nOvf;
      mEdges <= (k > 10) ? 10 : k;
      h3 <= h2; h2 <= h1; h1 <= startStop;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("modelDigits", {16'h0, dutDigits()}, {16'h0, toBcd(mCnt)});
      checkOutput("modelRunning", {31'h0, running}, {31'h0, mRun});
      checkOutput("modelOverflow", {31'h0, overflow}, {31'h0, mOvf});
      checkOutput("digitRange", {31'h0, (dig0 <= 4'd9 && dig1 <= 4'd9 && dig2 <= 4'd9 && dig3 <= 4'd9)}, 32'h1);
    end
  end

  task automatic applyStimulus(input int nCycles);
    for (int i = 0; i < nCycles; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) startStop = ~startStop;
      clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #1 checkOutput("randAsyncRst", {16'h0, dutDigits()}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stepEdges(3);
    rst = 1'b0;
    checkOutput("resetDigits", {16'h0, dutDigits()}, 32'h0);
    checkOutput("resetRunning", {31'h0, running}, 32'h0);
    checkOutput("resetOverflow", {31'h0, overflow}, 32'h0);
    stepEdges(5);

    // Start, then count from 0000: running rises on the third edge, ticks every fourth.
    startStop = 1'b1;
    stepEdges(2);
    checkOutput("runEdge2", {31'h0, running}, 32'h0);
    stepEdges(1);
    checkOutput("runEdge3", {31'h0, running}, 32'h1);
    stepEdges(2);
    startStop = 1'b0;
    stepEdges(33);
    checkOutput("count0008", {16'h0, dutDigits()}, 32'h0008);
    stepEdges(1);
    checkOutput("count0009", {16'h0, dutDigits()}, 32'h0009);
    stepEdges(3);
    checkOutput("hold0009", {16'h0, dutDigits()}, 32'h0009);
    stepEdges(1);
    checkOutput("count0010", {16'h0, dutDigits()}, 32'h0010);

    // Run up to the wrap.
    waitDigits(16'h9998, 45000);
    stepEdges(3);
    checkOutput("hold9998", {16'h0, dutDigits()}, 32'h9998);
    stepEdges(1);
    checkOutput("count9999", {16'h0, dutDigits()}, 32'h9999);
    checkOutput("ovfBeforeWrap", {31'h0, overflow}, 32'h0);
    stepEdges(4);
    checkOutput("wrap0000", {16'h0, dutDigits()}, 32'h0000);
    checkOutput("ovfAtWrap", {31'h0, overflow}, 32'h1);
    stepEdges(8);
    checkOutput("after0002", {16'h0, dutDigits()}, 32'h0002);
    checkOutput("ovfSticky", {31'h0, overflow}, 32'h1);

    // Pause two prescaler counts into a tick period, then resume.
    stepEdges(3);
    startStop = 1'b1;
    stepEdges(1);
    checkOutput("count0003", {16'h0, dutDigits()}, 32'h0003);
    stepEdges(2);
    checkOutput("stoppedMidTick", {31'h0, running}, 32'h0);
    stepEdges(1);
    startStop = 1'b0;
    stepEdges(20);
    checkOutput("idleHold", {16'h0, dutDigits()}, 32'h0003);
    startStop = 1'b1;
    stepEdges(3);
    checkOutput("resumed", {31'h0, running}, 32'h1);
    stepEdges(1);
    checkOutput("resume+1", {16'h0, dutDigits()}, 32'h0003);
    stepEdges(1);
    checkOutput("resume+2", {16'h0, dutDigits()}, 32'h0004);
    startStop = 1'b0;
    stepEdges(3);
    checkOutput("resume+5", {16'h0, dutDigits()}, 32'h0004);
    stepEdges(1);
    checkOutput("resume+6", {16'h0, dutDigits()}, 32'h0005);

    // Clear landing on the same edge as a tick and a button edge.
    waitDigits(16'h0123, 2000);
    stepEdges(1);
    startStop = 1'b1;
    stepEdges(2);
    clr = 1'b1;
    stepEdges(1);
    checkOutput("clrDigits", {16'h0, dutDigits()}, 32'h0);
    checkOutput("clrOverflow", {31'h0, overflow}, 32'h0);
    checkOutput("clrRunning", {31'h0, running}, 32'h0);
    clr = 1'b0;
    startStop = 1'b0;
    stepEdges(8);
    checkOutput("clrEdgeDropped", {31'h0, running}, 32'h0);
    checkOutput("clrStillZero", {16'h0, dutDigits()}, 32'h0);

    // Asynchronous reset while running at 0456, button held through release.
    startStop = 1'b1;
    stepEdges(3);
    checkOutput("restart", {31'h0, running}, 32'h1);
    startStop = 1'b0;
    waitDigits(16'h0456, 3000);
    #2 rst = 1'b1;
    startStop = 1'b1;
    #1;
    checkOutput("asyncRstDigits", {16'h0, dutDigits()}, 32'h0);
    checkOutput("asyncRstRunning", {31'h0, running}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    stepEdges(10);
    checkOutput("heldAcrossRst", {31'h0, running}, 32'h0);
    checkOutput("heldDigits", {16'h0, dutDigits()}, 32'h0);
    startStop = 1'b0;
    stepEdges(3);
    startStop = 1'b1;
    stepEdges(3);
    checkOutput("pressAfterRst", {31'h0, running}, 32'h1);
    startStop = 1'b0;

    applyStimulus(3000);
    stepEdges(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
